buffer_drain_tx: RTL and testbench

BUFFER_DRAIN_TX -- requirements
Module: buffer_drain_tx

---
 rtl/buffer_drain_tx_pkg.sv | 14 +
 rtl/buffer_drain_tx_if.sv | 31 +++
 rtl/buffer_drain_tx_credit_counter.sv | 30 +++
 rtl/buffer_drain_tx.sv | 69 ++++++
 tb/tb_buffer_drain_tx.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/buffer_drain_tx_pkg.sv
// Shared router definitions: drain FSM encoding and default geometry.
package buffer_drain_tx_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 16;
  localparam int unsigned DEPTH_DEF      = 5;
  localparam int unsigned CNT_WIDTH_DEF  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    STALL = 2'd2
  } tx_state_e;

endpackage

// File: rtl/buffer_drain_tx_if.sv
// Drain-side bundle: upstream buffer pop port, downstream credit link and status.
interface buffer_drain_tx_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 3
);
  logic                  tx_en_i;
  logic                  buf_empty_i;
  logic [DATA_WIDTH-1:0] buf_data_i;
  logic                  buf_read_o;
  logic                  credit_i;
  logic                  tx_valid_o;
  logic [DATA_WIDTH-1:0] tx_data_o;
  logic [CNT_WIDTH-1:0]  credit_cnt_o;
  logic [1:0]            state_o;
  logic [7:0]            tx_count_o;
  logic                  credit_err_o;

  // Drain engine side
  modport slave (
    input  tx_en_i, buf_empty_i, buf_data_i, credit_i,
    output buf_read_o, tx_valid_o, tx_data_o, credit_cnt_o, state_o,
           tx_count_o, credit_err_o
  );

  // Environment side (arbiter, buffer, downstream)
  modport master (
    output tx_en_i, buf_empty_i, buf_data_i, credit_i,
    input  buf_read_o, tx_valid_o, tx_data_o, credit_cnt_o, state_o,
           tx_count_o, credit_err_o
  );
endinterface

// File: rtl/buffer_drain_tx_credit_counter.sv
// Credit counter: starts full, saturates at MAX, sticky overflow flag.
module credit_counter #(
  parameter int unsigned MAX       = 5,
  parameter int unsigned CNT_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  input  logic                 dec,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 err
);

  // A simultaneous inc and dec cancel; an inc at MAX is held and flagged.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= CNT_WIDTH'(MAX);
      err <= 1'b0;
    end else if (inc && !dec) begin
      if (cnt == CNT_WIDTH'(MAX)) begin
        err <= 1'b1;
      end else begin
        cnt <= cnt + CNT_WIDTH'(1);
      end
    end else if (dec && !inc) begin
      cnt <= cnt - CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/buffer_drain_tx.sv
// Credit-gated drain of an upstream input buffer onto a downstream link.
module buffer_drain_tx #(
  parameter int unsigned DATA_WIDTH = buffer_drain_tx_pkg::DATA_WIDTH_DEF,
  parameter int unsigned DEPTH      = buffer_drain_tx_pkg::DEPTH_DEF,
  parameter int unsigned CNT_WIDTH  = buffer_drain_tx_pkg::CNT_WIDTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  buffer_drain_tx_if.slave  bus
);
  import buffer_drain_tx_pkg::*;

  logic                  rd;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  err;
  tx_state_e             state_q;
  logic                  tx_valid_q;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic [7:0]            tx_count_q;

  // Pop only with grant, data and a credit; never while reset is held.
  assign rd = reset & bus.tx_en_i & ~bus.buf_empty_i & (cnt != '0);

  credit_counter #(
    .MAX       (DEPTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_credit (
    .clk   (clk),
    .reset (reset),
    .inc   (bus.credit_i),
    .dec   (rd),
    .cnt   (cnt),
    .err   (err)
  );

  // Output flit register, valid strobe, sent-flit counter and state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      tx_count_q <= '0;
      state_q    <= IDLE;
    end else begin
      tx_valid_q <= rd;
      if (rd) begin
        tx_data_q <= bus.buf_data_i;
      end
      if (tx_valid_q) begin
        tx_count_q <= tx_count_q + 8'd1;
      end
      if (rd) begin
        state_q <= SEND;
      end else if (bus.tx_en_i && !bus.buf_empty_i && (cnt == '0)) begin
        state_q <= STALL;
      end else begin
        state_q <= IDLE;
      end
    end
  end

  assign bus.buf_read_o   = rd;
  assign bus.tx_valid_o   = tx_valid_q;
  assign bus.tx_data_o    = tx_data_q;
  assign bus.credit_cnt_o = cnt;
  assign bus.state_o      = state_q;
  assign bus.tx_count_o   = tx_count_q;
  assign bus.credit_err_o = err;

endmodule

// File: tb/tb_buffer_drain_tx.sv
// Scoreboard bench for buffer_drain_tx: directed phases push expected flits,
// a negedge monitor pops and compares every presented flit.
module tb_buffer_drain_tx;

  logic clk;
  logic reset;

  buffer_drain_tx_if #(.DATA_WIDTH(16), .CNT_WIDTH(3)) bus ();

  buffer_drain_tx #(
    .DATA_WIDTH (16),
    .DEPTH      (5),
    .CNT_WIDTH  (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] exp_q [$];

  // Upstream buffer model
  logic [15:0] mem [0:511];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          pops   = 0;
  logic        force_empty = 1'b0;
  logic        last_pop    = 1'b0;

  assign bus.buf_empty_i = (rd_ptr == wr_ptr) | force_empty;
  assign bus.buf_data_i  = mem[rd_ptr % 512];

  always @(posedge clk) begin
    last_pop <= bus.buf_read_o & reset;
    if (bus.buf_read_o) begin
      rd_ptr <= rd_ptr + 1;
      pops   <= pops + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: valid must follow a pop by one cycle; each flit matches the queue head.
  always @(negedge clk) begin
    chk("valid_follows_pop", {31'd0, bus.tx_valid_o}, {31'd0, last_pop});
    if (bus.tx_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_flit", bus.tx_data_o, 32'hFFFF_FFFF);
      end else begin
        chk("flit_data", {16'd0, bus.tx_data_o}, {16'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] d);
    mem[wr_ptr % 512] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    bus.tx_en_i  = 1'b0;
    bus.credit_i = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;

    // Reset and idle
    @(negedge clk);
    chk("rst_cnt", bus.credit_cnt_o, 5);
    chk("rst_state", bus.state_o, 0);
    chk("rst_valid", bus.tx_valid_o, 0);
    chk("rst_read", bus.buf_read_o, 0);
    chk("rst_data", bus.tx_data_o, 0);
    chk("rst_count", bus.tx_count_o, 0);
    chk("rst_err", bus.credit_err_o, 0);

    // Credit exhaustion: 7 flits, 5 credits
    cyc();
    for (int unsigned i = 1; i <= 7; i++) load(16'(i));
    for (int unsigned i = 1; i <= 5; i++) exp_q.push_back(16'(i));
    bus.tx_en_i = 1'b1;
    @(negedge clk);
    chk("exh_first_read", bus.buf_read_o, 1);
    for (int unsigned i = 0; i < 7; i++) cyc();
    @(negedge clk);
    chk("exh_pops", pops, 5);
    chk("exh_state", bus.state_o, 2);
    chk("exh_cnt", bus.credit_cnt_o, 0);
    chk("exh_read", bus.buf_read_o, 0);
    chk("exh_count", bus.tx_count_o, 5);

    // Credit return: one pulse releases one flit
    exp_q.push_back(16'h0006);
    cyc();
    bus.credit_i = 1'b1;
    cyc();
    bus.credit_i = 1'b0;
    @(negedge clk);
    chk("ret_read", bus.buf_read_o, 1);
    chk("ret_cnt1", bus.credit_cnt_o, 1);
    cyc();
    @(negedge clk);
    chk("ret_cnt0", bus.credit_cnt_o, 0);
    chk("ret_state_send", bus.state_o, 1);
    cyc();
    @(negedge clk);
    chk("ret_state_stall", bus.state_o, 2);
    chk("ret_pops", pops, 6);

    // Simultaneous pop and credit at cnt=2
    bus.tx_en_i  = 1'b0;
    bus.credit_i = 1'b1;
    cyc();
    cyc();
    bus.credit_i = 1'b0;
    @(negedge clk);
    chk("sim_cnt_pre", bus.credit_cnt_o, 2);
    exp_q.push_back(16'h0007);
    cyc();
    bus.tx_en_i  = 1'b1;
    bus.credit_i = 1'b1;
    @(negedge clk);
    chk("sim_read", bus.buf_read_o, 1);
    cyc();
    bus.tx_en_i  = 1'b0;
    bus.credit_i = 1'b0;
    @(negedge clk);
    chk("sim_cnt_post", bus.credit_cnt_o, 2);

    // Credit overflow at DEPTH
    bus.credit_i = 1'b1;
    cyc();
    cyc();
    cyc();
    bus.credit_i = 1'b0;
    @(negedge clk);
    chk("ovf_cnt_full", bus.credit_cnt_o, 5);
    chk("ovf_err_clear", bus.credit_err_o, 0);
    cyc();
    bus.credit_i = 1'b1;
    cyc();
    bus.credit_i = 1'b0;
    @(negedge clk);
    chk("ovf_cnt_held", bus.credit_cnt_o, 5);
    chk("ovf_err_set", bus.credit_err_o, 1);
    cyc();
    cyc();
    cyc();
    @(negedge clk);
    chk("ovf_err_sticky", bus.credit_err_o, 1);

    // Empty rises and grant drops mid-stream
    load(16'h0008);
    load(16'h0009);
    load(16'h000A);
    exp_q.push_back(16'h0008);
    exp_q.push_back(16'h0009);
    bus.tx_en_i = 1'b1;
    cyc();
    force_empty = 1'b1;
    @(negedge clk);
    chk("emp_read", bus.buf_read_o, 0);
    chk("emp_valid", bus.tx_valid_o, 1);
    cyc();
    @(negedge clk);
    chk("emp_state", bus.state_o, 0);
    chk("emp_valid_off", bus.tx_valid_o, 0);
    force_empty = 1'b0;
    cyc();
    bus.tx_en_i = 1'b0;
    @(negedge clk);
    chk("drop_read", bus.buf_read_o, 0);
    chk("drop_valid", bus.tx_valid_o, 1);
    cyc();
    @(negedge clk);
    chk("drop_state", bus.state_o, 0);
    chk("drop_cnt", bus.credit_cnt_o, 3);
    chk("drop_count", bus.tx_count_o, 9);

    // Counter wrap: 247 more flits brings the total to 256
    exp_q.push_back(16'h000A);
    for (int unsigned i = 0; i < 246; i++) begin
      load(16'h0100 + 16'(i));
      exp_q.push_back(16'h0100 + 16'(i));
    end
    bus.tx_en_i  = 1'b1;
    bus.credit_i = 1'b1;
    begin
      int unsigned budget;
      budget = 0;
      while (rd_ptr != wr_ptr && budget < 400) begin
        cyc();
        budget++;
      end
      if (rd_ptr != wr_ptr) chk("wrap_timeout", rd_ptr, wr_ptr);
    end
    bus.tx_en_i  = 1'b0;
    bus.credit_i = 1'b0;
    cyc();
    cyc();
    cyc();
    @(negedge clk);
    chk("wrap_pops", pops, 256);
    chk("wrap_count", bus.tx_count_o, 0);

    // Reset while a pop would otherwise be legal
    load(16'h0BAD);
    bus.tx_en_i = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst2_read", bus.buf_read_o, 0);
    cyc();
    @(negedge clk);
    chk("rst2_valid", bus.tx_valid_o, 0);
    chk("rst2_cnt", bus.credit_cnt_o, 5);
    chk("rst2_err", bus.credit_err_o, 0);
    chk("rst2_count", bus.tx_count_o, 0);
    chk("rst2_data", bus.tx_data_o, 0);
    chk("rst2_state", bus.state_o, 0);
    bus.tx_en_i = 1'b0;
    reset = 1'b1;
    cyc();
    cyc();
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
